reg_file_wb: RTL and testbench

REG_FILE_WB -- requirements
Module: reg_file_wb

---
 rtl/reg_file_wb_if.sv | 35 +++
 rtl/reg_file_wb.sv | 63 ++++++
 tb/tb_reg_file_wb.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_wb_if.sv
// Register-file / writeback bus: read ports, writeback sources and retire count.
// Latency: n/a (signal bundle only).
// Backpressure: none; every signal is sampled or driven every cycle.
interface reg_file_wb_if #(
  parameter int XLEN = 32
);
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rv1;
  logic [XLEN-1:0] rv2;
  logic            wb_en;
  logic [1:0]      wb_sel;
  logic [XLEN-1:0] regdata_R;
  logic [XLEN-1:0] regdata_I;
  logic [XLEN-1:0] ldata;
  logic [XLEN-1:0] pc_plus4;
  logic [4:0]      rd_addr;
  logic            retire;
  logic [XLEN-1:0] wb_data;
  logic [63:0]     instret;

  // Pipeline side: drives addresses, sources and control; observes read data.
  modport master (
    output rs1_addr, rs2_addr, wb_en, wb_sel, regdata_R, regdata_I,
           ldata, pc_plus4, rd_addr, retire,
    input  rv1, rv2, wb_data, instret
  );

  // Register file side.
  modport slave (
    input  rs1_addr, rs2_addr, wb_en, wb_sel, regdata_R, regdata_I,
           ldata, pc_plus4, rd_addr, retire,
    output rv1, rv2, wb_data, instret
  );
endinterface

// File: rtl/reg_file_wb.sv
// Two-read/one-write integer register file with writeback mux and instret counter.
// Latency: reads and wb_data are combinational; writes land on the next rising edge.
// Backpressure: none; a write or retire presented in a cycle is always accepted.
module reg_file_wb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_wb_if.slave  bus
);

  logic [XLEN-1:0] regs [NREGS];
  logic [63:0]     instret_cnt;
  logic [XLEN-1:0] wb_mux;

  // Index 0 is hardwired zero; indices past the implemented range alias x0.
  function automatic logic idx_live(input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < NREGS);
  endfunction

  // Writeback source select; purely combinational so trace sees it immediately.
  always_comb begin
    wb_mux = bus.regdata_R;
    case (bus.wb_sel)
      2'd0: wb_mux = bus.regdata_R;
      2'd1: wb_mux = bus.regdata_I;
      2'd2: wb_mux = bus.ldata;
      2'd3: wb_mux = bus.pc_plus4;
      default: wb_mux = bus.regdata_R;
    endcase
  end

  assign bus.wb_data = wb_mux;

  // No bypass from the write port: a same-cycle read sees the old value,
  // which keeps rv -> ALU -> regdata_R from forming a combinational loop.
  assign bus.rv1 = (rst_n && idx_live(bus.rs1_addr)) ? regs[bus.rs1_addr] : '0;
  assign bus.rv2 = (rst_n && idx_live(bus.rs2_addr)) ? regs[bus.rs2_addr] : '0;

  // Register array: async clear, single write port gated by x0/range guard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.wb_en && idx_live(bus.rd_addr)) begin
      regs[bus.rd_addr] <= wb_mux;
    end
  end

  // Retired-instruction counter; free-running wrap at 2^64, independent of wb_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_cnt <= '0;
    end else if (bus.retire) begin
      instret_cnt <= instret_cnt + 64'd1;
    end
  end

  assign bus.instret = instret_cnt;

endmodule

// File: tb/tb_reg_file_wb.sv
module tb_reg_file_wb;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  reg_file_wb_if #(.XLEN(32)) bus ();

  reg_file_wb #(.XLEN(32), .NREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural register contents and retire count.
  logic [31:0] mregs [32];
  logic [63:0] minstret;

  function automatic logic [31:0] mread(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : mregs[a];
  endfunction

  function automatic logic [31:0] msel(input logic [1:0] s);
    logic [31:0] srcs [4];
    srcs = '{bus.regdata_R, bus.regdata_I, bus.ldata, bus.pc_plus4};
    return srcs[s];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    minstret = 64'd0;
  endtask

  // Advance one clock: apply the architectural effect of the current inputs
  // at the rising edge, return at the following falling edge.
  task automatic tick();
    logic [31:0] v;
    v = msel(bus.wb_sel);
    @(posedge clk);
    if (rst_n) begin
      if (bus.wb_en && bus.rd_addr != 5'd0) mregs[bus.rd_addr] = v;
      if (bus.retire) minstret = minstret + 64'd1;
    end
    @(negedge clk);
  endtask

  task automatic drive_wr(input logic en, input logic [1:0] sel, input logic [4:0] rd,
                          input logic [31:0] r, input logic [31:0] i,
                          input logic [31:0] l, input logic [31:0] p);
    bus.wb_en = en; bus.wb_sel = sel; bus.rd_addr = rd;
    bus.regdata_R = r; bus.regdata_I = i; bus.ldata = l; bus.pc_plus4 = p;
  endtask

  task automatic test_reset();
    bus.rs1_addr = 5'd3; bus.rs2_addr = 5'd31;
    #1;
    vectors++;
    if (bus.rv1 !== 32'd0) begin miscompares++; $display("FAIL reset_rv1 got %h want 0", bus.rv1); end
    vectors++;
    if (bus.rv2 !== 32'd0) begin miscompares++; $display("FAIL reset_rv2 got %h want 0", bus.rv2); end
    vectors++;
    if (bus.instret !== 64'd0) begin miscompares++; $display("FAIL reset_instret got %h want 0", bus.instret); end
    // A write and a retire held across an edge in reset must be blocked.
    drive_wr(1'b1, 2'd0, 5'd3, 32'hA5A5A5A5, 0, 0, 0);
    bus.retire = 1'b1;
    tick();
    vectors++;
    if (bus.rv1 !== 32'd0) begin miscompares++; $display("FAIL reset_blocks_write got %h want 0", bus.rv1); end
    vectors++;
    if (bus.instret !== 64'd0) begin miscompares++; $display("FAIL reset_blocks_count got %h want 0", bus.instret); end
    drive_wr(1'b0, 2'd0, 5'd0, 0, 0, 0, 0);
    bus.retire = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_x0_guard();
    drive_wr(1'b1, 2'd0, 5'd0, 32'hFFFFFFFF, 0, 0, 0);
    bus.rs1_addr = 5'd0;
    #1;
    vectors++;
    if (bus.wb_data !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL x0_wb_data got %h want ffffffff", bus.wb_data); end
    tick();
    bus.wb_en = 1'b0;
    #1;
    vectors++;
    if (bus.rv1 !== 32'd0) begin miscompares++; $display("FAIL x0_guard got %h want 0", bus.rv1); end
  endtask

  task automatic test_mux_sweep();
    logic [31:0] want [4];
    want = '{32'd1, 32'd2, 32'd3, 32'h104};
    for (int s = 0; s < 4; s++) begin
      drive_wr(1'b1, 2'(s), 5'(s + 1), 32'd1, 32'd2, 32'd3, 32'h104);
      #1;
      vectors++;
      if (bus.wb_data !== want[s]) begin miscompares++; $display("FAIL mux_wb_data sel=%0d got %h want %h", s, bus.wb_data, want[s]); end
      tick();
    end
    bus.wb_en = 1'b0;
    for (int s = 0; s < 4; s++) begin
      bus.rs1_addr = 5'(s + 1);
      bus.rs2_addr = 5'(s + 1);
      #1;
      vectors++;
      if (bus.rv1 !== want[s]) begin miscompares++; $display("FAIL mux_read x%0d got %h want %h", s + 1, bus.rv1, want[s]); end
    end
  endtask

  task automatic test_read_during_write();
    drive_wr(1'b1, 2'd1, 5'd7, 0, 32'h11, 0, 0);
    tick();
    drive_wr(1'b1, 2'd1, 5'd7, 0, 32'h22, 0, 0);
    bus.rs1_addr = 5'd7;
    #1;
    vectors++;
    if (bus.rv1 !== 32'h11) begin miscompares++; $display("FAIL rdw_same_cycle got %h want 00000011", bus.rv1); end
    tick();
    bus.wb_en = 1'b0;
    #1;
    vectors++;
    if (bus.rv1 !== 32'h22) begin miscompares++; $display("FAIL rdw_next_cycle got %h want 00000022", bus.rv1); end
  endtask

  task automatic test_dual_read();
    drive_wr(1'b1, 2'd2, 5'd31, 0, 0, 32'h80000000, 0);
    tick();
    bus.wb_en = 1'b0;
    bus.rs1_addr = 5'd31; bus.rs2_addr = 5'd31;
    #1;
    vectors++;
    if (bus.rv1 !== 32'h80000000) begin miscompares++; $display("FAIL dual_rv1 got %h want 80000000", bus.rv1); end
    vectors++;
    if (bus.rv2 !== 32'h80000000) begin miscompares++; $display("FAIL dual_rv2 got %h want 80000000", bus.rv2); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive_wr(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
               $urandom, $urandom, $urandom, $urandom);
      bus.retire   = 1'($urandom_range(0, 1));
      bus.rs1_addr = 5'($urandom_range(0, 31));
      bus.rs2_addr = (n % 5 == 0) ? bus.rs1_addr : 5'($urandom_range(0, 31));
      #1;
      vectors++;
      if (bus.rv1 !== mread(bus.rs1_addr)) begin miscompares++; $display("FAIL rand_rv1 n=%0d a=%0d got %h want %h", n, bus.rs1_addr, bus.rv1, mread(bus.rs1_addr)); end
      vectors++;
      if (bus.rv2 !== mread(bus.rs2_addr)) begin miscompares++; $display("FAIL rand_rv2 n=%0d a=%0d got %h want %h", n, bus.rs2_addr, bus.rv2, mread(bus.rs2_addr)); end
      vectors++;
      if (bus.wb_data !== msel(bus.wb_sel)) begin miscompares++; $display("FAIL rand_wb_data n=%0d got %h want %h", n, bus.wb_data, msel(bus.wb_sel)); end
      vectors++;
      if (bus.instret !== minstret) begin miscompares++; $display("FAIL rand_instret n=%0d got %0d want %0d", n, bus.instret, minstret); end
      tick();
    end
    drive_wr(1'b0, 2'd0, 5'd0, 0, 0, 0, 0);
    bus.retire = 1'b0;
  endtask

  task automatic test_counter_wrap();
    force dut.instret_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_cnt;
    minstret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    vectors++;
    if (bus.instret !== minstret) begin miscompares++; $display("FAIL wrap_preload got %h want %h", bus.instret, minstret); end
    bus.retire = 1'b1;
    tick();
    vectors++;
    if (bus.instret !== 64'd0) begin miscompares++; $display("FAIL wrap_to_zero got %h want 0", bus.instret); end
    bus.retire = 1'b0;
    tick();
    tick();
    vectors++;
    if (bus.instret !== 64'd0) begin miscompares++; $display("FAIL wrap_hold got %h want 0", bus.instret); end
  endtask

  task automatic test_reset_midrun();
    drive_wr(1'b1, 2'd0, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    bus.retire = 1'b1;
    tick();
    bus.rs1_addr = 5'd5;
    drive_wr(1'b1, 2'd0, 5'd6, 32'h1234, 0, 0, 0);
    #1;
    vectors++;
    if (bus.rv1 !== 32'hDEADBEEF) begin miscompares++; $display("FAIL midrun_pre got %h want deadbeef", bus.rv1); end
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    vectors++;
    if (bus.rv1 !== 32'd0) begin miscompares++; $display("FAIL midrun_rv1 got %h want 0", bus.rv1); end
    vectors++;
    if (bus.instret !== 64'd0) begin miscompares++; $display("FAIL midrun_instret got %h want 0", bus.instret); end
    tick();
    drive_wr(1'b0, 2'd0, 5'd0, 0, 0, 0, 0);
    bus.retire = 1'b0;
    rst_n = 1'b1;
    bus.rs1_addr = 5'd6;
    #1;
    vectors++;
    if (bus.rv1 !== 32'd0) begin miscompares++; $display("FAIL midrun_dropped_write got %h want 0", bus.rv1); end
    tick();
    vectors++;
    if (bus.instret !== minstret) begin miscompares++; $display("FAIL midrun_post_instret got %h want %h", bus.instret, minstret); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    model_clear();
    drive_wr(1'b0, 2'd0, 5'd0, 0, 0, 0, 0);
    bus.retire = 1'b0;
    bus.rs1_addr = 5'd0;
    bus.rs2_addr = 5'd0;
    @(negedge clk);
    test_reset();
    test_x0_guard();
    test_mux_sweep();
    test_read_during_write();
    test_dual_read();
    test_random();
    test_counter_wrap();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
